// File: rtl/bcd_scan_controller.sv
// Scans a double-buffered word of BCD digits onto one shared decoder input.
// A one-hot strobe selects the digit. New words take effect only at frame boundaries.
module bcd_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Enable,
   input  logic                    LoadValid,
   input  logic [4*NUM_DIGITS-1:0] LoadData,
   output logic                    LoadReady,
   input  logic                    ErrClr,
   output logic [3:0]              BCDOut,
   output logic [NUM_DIGITS-1:0]   DigitSel,
   output logic                    DigitValid,
   output logic                    ErrFlag
);

   localparam int IW      = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] P_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] B_LAST   = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
   localparam bit            NO_BLANK = (BLANK_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOW = 2'd1, S_BLANK = 2'd2} state_t;

   function automatic logic has_bad_digit(input logic [4*NUM_DIGITS-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bad = bad | (w[4*i +: 4] > 4'd9);
      end
      return bad;
   endfunction

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d, active_q, active_d;
   logic                    pending_full_q, pending_full_d, loaded_q, loaded_d;
   logic                    err_q, err_d, ready_q;
   logic [3:0]              bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    valid_q, valid_d;
   logic                    accept_s, boundary_s, transfer_s;
   logic [IW-1:0]           idx_next_s;
   logic [3:0]              digit_s;

   // Buffer handshake, boundary transfer and sticky error flag
   always_comb begin
      accept_s   = LoadValid & ready_q;
      boundary_s = (idx_q == IDX_LAST) &&
                   (((state_q == S_BLANK) && (cnt_q == B_LAST)) ||
                    ((state_q == S_SHOW) && (cnt_q == P_LAST) && NO_BLANK));
      // accept needs an empty pending buffer and transfer a full one, so they never coincide
      transfer_s = pending_full_q & (boundary_s | (state_q == S_IDLE));
      pending_d  = accept_s ? LoadData : pending_q;
      active_d   = transfer_s ? pending_q : active_q;
      loaded_d   = loaded_q | transfer_s;
      if (transfer_s) begin
         pending_full_d = 1'b0;
      end else if (accept_s) begin
         pending_full_d = 1'b1;
      end else begin
         pending_full_d = pending_full_q;
      end
      if (accept_s && has_bad_digit(LoadData)) begin
         err_d = 1'b1;
      end else if (ErrClr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Next-state logic for the scan FSM
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      idx_next_s = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            cnt_d = '0;
            if (Enable && loaded_d) begin
               state_d = S_SHOW;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHOW: begin
            if (!Enable) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == P_LAST) begin
               cnt_d = '0;
               if (NO_BLANK) begin
                  idx_d = idx_next_s;
               end else begin
                  state_d = S_BLANK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_BLANK: begin
            if (!Enable) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == B_LAST) begin
               state_d = S_SHOW;
               idx_d   = idx_next_s;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values derived from the next state so that outputs are registered with it
   always_comb begin
      digit_s = active_d[4*idx_d +: 4];
      bcd_d   = bcd_q;
      sel_d   = '0;
      valid_d = 1'b0;
      if (state_d == S_SHOW) begin
         bcd_d = digit_s;
         if (digit_s <= 4'd9) begin
            sel_d   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
            valid_d = 1'b1;
         end else begin
            sel_d   = '0;
            valid_d = 1'b0;
         end
      end else begin
         sel_d   = '0;
         valid_d = 1'b0;
      end
   end

   // State, buffer and output registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         cnt_q          <= '0;
         pending_q      <= '0;
         active_q       <= '0;
         pending_full_q <= 1'b0;
         loaded_q       <= 1'b0;
         err_q          <= 1'b0;
         ready_q        <= 1'b1;
         bcd_q          <= 4'd0;
         sel_q          <= '0;
         valid_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         pending_q      <= pending_d;
         active_q       <= active_d;
         pending_full_q <= pending_full_d;
         loaded_q       <= loaded_d;
         err_q          <= err_d;
         ready_q        <= ~pending_full_d;
         bcd_q          <= bcd_d;
         sel_q          <= sel_d;
         valid_q        <= valid_d;
      end
   end

   assign LoadReady  = ready_q;
   assign BCDOut     = bcd_q;
   assign DigitSel   = sel_q;
   assign DigitValid = valid_q;
   assign ErrFlag    = err_q;

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Drives two configurations in lockstep (4/1 and 1/0 dwell/blank) and compares
// every output each cycle against a frame-position reference model.
module tb_bcd_scan_controller;

   localparam int N     = 4;
   localparam int PS[2] = '{4, 1};
   localparam int BL[2] = '{1, 0};

   logic        clk = 1'b0;
   logic        rst, en, lv, eclr;
   logic [15:0] ld;
   logic        rdy   [2];
   logic [3:0]  bcd   [2];
   logic [3:0]  sel   [2];
   logic        val   [2];
   logic        errf  [2];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: running flag plus position within the frame
   bit          m_run    [2];
   int          m_pos    [2];
   bit          m_pfull  [2];
   logic [15:0] m_pend   [2];
   logic [15:0] m_act    [2];
   bit          m_loaded [2];
   bit          m_err    [2];
   logic [3:0]  m_bcd    [2];
   logic [3:0]  m_sel    [2];
   bit          m_val    [2];

   always #5 clk = ~clk;

   bcd_scan_controller #(.NUM_DIGITS(N), .PRESCALE(4), .BLANK_CYCLES(1)) dut0 (
      .Clk(clk), .Rst(rst), .Enable(en), .LoadValid(lv), .LoadData(ld),
      .LoadReady(rdy[0]), .ErrClr(eclr), .BCDOut(bcd[0]), .DigitSel(sel[0]),
      .DigitValid(val[0]), .ErrFlag(errf[0]));

   bcd_scan_controller #(.NUM_DIGITS(N), .PRESCALE(1), .BLANK_CYCLES(0)) dut1 (
      .Clk(clk), .Rst(rst), .Enable(en), .LoadValid(lv), .LoadData(ld),
      .LoadReady(rdy[1]), .ErrClr(eclr), .BCDOut(bcd[1]), .DigitSel(sel[1]),
      .DigitValid(val[1]), .ErrFlag(errf[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit any_bad(input logic [15:0] w);
      bit b = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w[4*i +: 4] > 4'd9) b = 1'b1;
      end
      return b;
   endfunction

   task automatic model_step(input int k);
      int  slot, frame, d;
      bit  acc, bnd, xfer;
      slot  = PS[k] + BL[k];
      frame = N * slot;
      if (rst) begin
         m_run[k] = 1'b0; m_pos[k] = 0; m_pfull[k] = 1'b0; m_pend[k] = 16'h0;
         m_act[k] = 16'h0; m_loaded[k] = 1'b0; m_err[k] = 1'b0;
         m_bcd[k] = 4'h0; m_sel[k] = 4'h0; m_val[k] = 1'b0;
      end else begin
         acc  = lv && !m_pfull[k];
         bnd  = m_run[k] && (m_pos[k] == frame - 1);
         xfer = m_pfull[k] && (!m_run[k] || bnd);
         if (xfer) begin
            m_act[k] = m_pend[k]; m_loaded[k] = 1'b1; m_pfull[k] = 1'b0;
         end
         if (acc) begin
            m_pend[k] = ld; m_pfull[k] = 1'b1;
         end
         if (acc && any_bad(ld)) m_err[k] = 1'b1;
         else if (eclr)          m_err[k] = 1'b0;
         if (m_run[k]) begin
            if (!en) begin
               m_run[k] = 1'b0; m_pos[k] = 0;
            end else begin
               m_pos[k] = (m_pos[k] + 1) % frame;
            end
         end else if (en && m_loaded[k]) begin
            m_run[k] = 1'b1; m_pos[k] = 0;
         end
         if (m_run[k] && (m_pos[k] % slot) < PS[k]) begin
            d        = m_pos[k] / slot;
            m_bcd[k] = m_act[k][4*d +: 4];
            m_val[k] = (m_bcd[k] <= 4'd9);
            m_sel[k] = m_val[k] ? 4'(1 << d) : 4'h0;
         end else begin
            m_sel[k] = 4'h0; m_val[k] = 1'b0;
         end
      end
   endtask

   task automatic cyc(input int n);
      for (int c = 0; c < n; c++) begin
         for (int k = 0; k < 2; k++) model_step(k);
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            check($sformatf("bcd%0d", k),   32'(bcd[k]),  32'(m_bcd[k]));
            check($sformatf("sel%0d", k),   32'(sel[k]),  32'(m_sel[k]));
            check($sformatf("valid%0d", k), 32'(val[k]),  32'(m_val[k]));
            check($sformatf("ready%0d", k), 32'(rdy[k]),  32'(!m_pfull[k]));
            check($sformatf("err%0d", k),   32'(errf[k]), 32'(m_err[k]));
         end
      end
   endtask

   task automatic load(input logic [15:0] w);
      lv = 1'b1; ld = w;
      cyc(1);
      lv = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; lv = 1'b0; ld = 16'h0; eclr = 1'b0;
      #1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      // basic scan of 1234
      en = 1'b1;
      load(16'h1234);
      cyc(45);
      // mid-frame load, then a second offer while not ready
      load(16'h5678);
      lv = 1'b1; ld = 16'h1111;
      cyc(2);
      lv = 1'b0;
      cyc(45);
      // invalid digits and error flag behaviour
      load(16'h9A01);
      cyc(25);
      eclr = 1'b1;
      cyc(1);
      eclr = 1'b0;
      cyc(3);
      lv = 1'b1; ld = 16'hF000; eclr = 1'b1;
      cyc(1);
      lv = 1'b0; eclr = 1'b0;
      cyc(25);
      // enable drop mid-frame and re-enable
      load(16'h1234);
      cyc(32);
      en = 1'b0;
      cyc(3);
      en = 1'b1;
      cyc(12);
      load(16'h0987);
      cyc(25);
      // reset mid-frame with a pending word
      load(16'h1111);
      lv = 1'b1; ld = 16'h2222;
      cyc(1);
      lv = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(12);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         en   = ($urandom_range(0, 15) != 0);
         lv   = ($urandom_range(0, 5) == 0);
         ld   = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            for (int j = 0; j < N; j++) ld[4*j +: 4] = 4'($urandom_range(0, 9));
         end
         eclr = ($urandom_range(0, 20) == 0);
         rst  = ($urandom_range(0, 200) == 0);
         cyc(1);
      end
      rst = 1'b0; lv = 1'b0; eclr = 1'b0;
      cyc(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Time-multiplexed scan controller for a bank of BCD digits sharing one BCD-to-decimal decoder. It holds a double-buffered word of NUM_DIGITS BCD digits. It presents one digit at a time on BCDOut, which feeds the shared decoder, and drives a one-hot digit-select strobe, with a programmable dwell and a blanking gap between digits. New words are loaded through a valid/ready handshake and take effect only at frame boundaries, so a displayed frame is never torn.

## Interface
- NUM_DIGITS, 4: number of digits scanned per frame (2..8).
- PRESCALE, 4: clock cycles each digit is shown (≥1).
- BLANK_CYCLES, 1: clock cycles of blanking after each digit (≥0; 0 = no blank state).
- Clk  input  1  system clock, rising edge.
- Rst  input  1  reset: synchronous, active-high.
- Enable  input  1  scan enable; low forces outputs idle.
- LoadValid  input  1  new digit word offered.
- LoadData  input  4*NUM_DIGITS  digit i = LoadData[4i+3:4i]; digit 0 is scanned first.
- LoadReady  output  1  pending buffer empty; word accepted when LoadValid & LoadReady.
- ErrClr  input  1  clears ErrFlag.
- BCDOut  output  4  BCD code of the current digit, to the decoder input.
- DigitSel  output  NUM_DIGITS  one-hot strobe of the digit being shown; all-zero when blanked or idle.
- DigitValid  output  1  high while a valid digit (0..9) is shown.
- ErrFlag  output  1  sticky: an accepted word contained a digit > 9.

## Operation
- Storage: a pending buffer (plus full bit) and an active buffer (plus loaded bit).
- Accept: on LoadValid & LoadReady, LoadData goes into pending and pending becomes full. LoadReady = !pending_full, registered.
- Transfer (pending → active, pending cleared, loaded set) happens on either of two conditions:
  - the frame boundary, i.e. the last cycle of the last digit's slot, including its BLANK cycles;
  - any cycle in IDLE while pending is full.
- A word is never accepted and transferred in the same cycle. The transfer always moves the word accepted earlier.
- States: IDLE, SHOW, BLANK.
  - IDLE: DigitSel=0, DigitValid=0, idx=0, cnt=0. Go to SHOW(idx=0) when Enable & loaded.
  - SHOW: DigitSel=onehot(idx), BCDOut=active[idx], cnt counts 0..PRESCALE-1. At PRESCALE-1, go to BLANK, or to SHOW(idx+1) if BLANK_CYCLES=0.
  - BLANK: DigitSel=0, DigitValid=0, BCDOut holds its last value, cnt counts 0..BLANK_CYCLES-1. At the end, go to SHOW(idx+1).
  - idx wraps NUM_DIGITS-1 → 0. This is the frame boundary.
- Invalid digit (>9) in the active buffer: its SHOW slot runs full length with DigitSel=0, DigitValid=0, and BCDOut carrying the raw code.
- ErrFlag is set in the accept cycle if any digit of LoadData is > 9. ErrClr clears it. If set and clear happen in the same cycle, set wins.
- Enable low in SHOW/BLANK: next cycle goes to IDLE, with idx and cnt zeroed. Loading continues. An IDLE transfer still occurs.
- Rst mid-frame: all state returns to reset values on the next edge, and both buffers are emptied.

## Timing
- All outputs are registered.
- Reset values: BCDOut=0, DigitSel=0, DigitValid=0, LoadReady=1, ErrFlag=0. State IDLE, idx=0, cnt=0, pending empty, active not loaded.
- Frame length = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles. With defaults this is 20.
- Load sequence with Enable already high and the controller in IDLE:
  - cycle t: word accepted; LoadReady=0 at t+1.
  - cycle t+1: transfer; LoadReady=1 at t+2.
  - cycle t+2: first SHOW output.
- Enable rise with loaded=1: SHOW digit 0 is visible on the next cycle.
- Word accepted mid-frame: becomes visible in the first SHOW slot after the next boundary. LoadReady stays 0 until that boundary.
- Enable fall: outputs idle one cycle later.

## Test plan
- Reset, then Enable=1 and load 16'h1234 (defaults). Required: BCDOut=4,3,2,1 with DigitSel=0001,0010,0100,1000. Each digit is shown 4 cycles, followed by 1 blank cycle with DigitSel=0. The frame repeats every 20 cycles.
- Mid-frame, load 16'h5678 while 16'h1234 is scanning. Required:
  - LoadReady=0 from the next cycle until the boundary;
  - the current frame finishes as 4,3,2,1;
  - the next frame shows 8,7,6,5;
  - a second LoadValid while LoadReady=0 is ignored.
- Load 16'h9A01. Required:
  - ErrFlag=1 one cycle after accept;
  - the digit-2 slot shows BCDOut=A with DigitSel=0 and DigitValid=0;
  - ErrClr pulsed alone clears ErrFlag;
  - ErrClr together with an accepted load of 16'hF000 leaves ErrFlag=1.
- Drop Enable during SHOW of digit 2. Required: next cycle DigitSel=0 and IDLE. On re-enable, scanning restarts at digit 0 one cycle later.
- Rebuild with BLANK_CYCLES=0 and PRESCALE=1, then load 16'h0987. Required: DigitSel rotates every cycle, the frame is 4 cycles, and there is no all-zero DigitSel cycle.
- Assert Rst for one cycle mid-frame with a pending word. Required: all outputs at reset values and LoadReady=1. The old active word is not displayed after Enable until a new load.
